// File: rtl/lsu_sequencer_if.sv
// Word-wide memory port between the load/store sequencer and memory.
//   mem_en    : access request, held until mem_ack
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word address (byte address [31:2])
//   mem_wdata : write data
//   mem_rdata : read data, sampled with mem_ack
//   mem_ack   : access complete this cycle
// The master modport is the sequencer side; the slave modport is the memory side.
interface lsu_sequencer_if;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: turns one core load/store request into word-wide
// memory accesses, with sub-word stores done as read-modify-write, sub-word
// loads lane-extracted and extended, misalignment detection and a bus timeout.
// Ports:
//   clk, reset (synchronous, active-low)
//   req_valid/req_ready       : request handshake
//   mem_wr, ld_size           : 00 none, 01 word, 10 half, 11 byte
//   ld_unsigned, addr, wdata  : request attributes, latched on acceptance
//   rsp_valid, rdata,
//   misalign, err             : one-cycle completion with status
//   stall                     : holds core PC / register-file write
//   mem                       : word-wide memory port (master side)
//
// state  | meaning
// IDLE   | waiting for a request
// RD     | load read, waiting for mem_ack
// RMW_RD | read of the word to be partially overwritten
// WR     | write of full or merged word, waiting for mem_ack
// RESP   | one-cycle rsp_valid pulse
module lsu_sequencer #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  mem_wr,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        err,
  output logic        stall,
  lsu_sequencer_if.master mem
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  lane;
  logic [1:0]  size;
  logic        uns;
  logic [15:0] wsub;

  logic [1:0]  req_size;
  logic        req_null;
  logic        req_mis;
  logic        accept;
  logic        in_wait;
  logic        timed_out;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] ld_data;
  logic [31:0] merged;

  // A nonzero store size wins over the load size.
  assign req_size  = (mem_wr != 2'b00) ? mem_wr : ld_size;
  assign req_null  = (req_size == 2'b00);
  assign req_mis   = ((req_size == 2'b01) && (addr[1:0] != 2'b00)) ||
                     ((req_size == 2'b10) && addr[0]);
  assign req_ready = (state == IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign in_wait   = (state == RD) || (state == RMW_RD) || (state == WR);
  assign timed_out = (wait_cnt == TIMEOUT);
  assign stall     = in_wait || (accept && !req_null);

  always_comb begin
    byte_lane = mem.mem_rdata[{lane, 3'b000} +: 8];
    half_lane = lane[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (size)
      2'b11:   ld_data = uns ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b10:   ld_data = uns ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: ld_data = mem.mem_rdata;
    endcase
    merged = mem.mem_rdata;
    case (size)
      2'b11:   merged[{lane, 3'b000} +: 8] = wsub[7:0];
      2'b10:   merged[{lane[1], 4'b0000} +: 16] = wsub;
      default: merged = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      lane          <= 2'b00;
      size          <= 2'b00;
      uns           <= 1'b0;
      wsub          <= 16'h0;
      rsp_valid     <= 1'b0;
      rdata         <= 32'h0;
      misalign      <= 1'b0;
      err           <= 1'b0;
      mem.mem_en    <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 30'h0;
      mem.mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lane     <= addr[1:0];
            size     <= req_size;
            uns      <= ld_unsigned;
            wsub     <= wdata[15:0];
            wait_cnt <= 8'd0;
            if (!req_null) begin
              if (req_mis) begin
                // No memory access at all for a misaligned request.
                state     <= RESP;
                rsp_valid <= 1'b1;
                misalign  <= 1'b1;
                rdata     <= 32'h0;
              end else begin
                mem.mem_en   <= 1'b1;
                mem.mem_addr <= addr[31:2];
                if (mem_wr == 2'b00) begin
                  state      <= RD;
                  mem.mem_we <= 1'b0;
                end else if (mem_wr == 2'b01) begin
                  state         <= WR;
                  mem.mem_we    <= 1'b1;
                  mem.mem_wdata <= wdata;
                end else begin
                  state      <= RMW_RD;
                  mem.mem_we <= 1'b0;
                end
              end
            end
          end
        end
        RD: begin
          if (mem.mem_ack) begin
            state      <= RESP;
            wait_cnt   <= 8'd0;
            mem.mem_en <= 1'b0;
            rsp_valid  <= 1'b1;
            rdata      <= ld_data;
          end else if (timed_out) begin
            state      <= RESP;
            wait_cnt   <= 8'd0;
            mem.mem_en <= 1'b0;
            rsp_valid  <= 1'b1;
            err        <= 1'b1;
            rdata      <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RMW_RD: begin
          if (mem.mem_ack) begin
            // mem_en stays high: the write follows straight on.
            state         <= WR;
            wait_cnt      <= 8'd0;
            mem.mem_we    <= 1'b1;
            mem.mem_wdata <= merged;
          end else if (timed_out) begin
            state      <= RESP;
            wait_cnt   <= 8'd0;
            mem.mem_en <= 1'b0;
            rsp_valid  <= 1'b1;
            err        <= 1'b1;
            rdata      <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WR: begin
          if (mem.mem_ack || timed_out) begin
            state      <= RESP;
            wait_cnt   <= 8'd0;
            mem.mem_en <= 1'b0;
            mem.mem_we <= 1'b0;
            rsp_valid  <= 1'b1;
            err        <= !mem.mem_ack;
            rdata      <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          wait_cnt  <= 8'd0;
          rsp_valid <= 1'b0;
          misalign  <= 1'b0;
          err       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
module tb_lsu_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  mem_wr = 2'b00;
  logic [1:0]  ld_size = 2'b00;
  logic        ld_unsigned = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        req_ready, rsp_valid, misalign, err, stall;
  logic [31:0] rdata;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0, wr_cnt = 0, en_cnt = 0, rsp_cnt = 0, wait_seen = 0;
  int ack_delay = 0;
  int lat;
  int s_rd, s_wr, s_en, s_rsp;

  logic [31:0] mem_arr [0:255];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = 8'h0;
  logic [31:0] poke_val = 32'h0;

  lsu_sequencer_if bus();

  lsu_sequencer #(.TIMEOUT(8'd4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .mem_wr      (mem_wr),
    .ld_size     (ld_size),
    .ld_unsigned (ld_unsigned),
    .addr        (addr),
    .wdata       (wdata),
    .rsp_valid   (rsp_valid),
    .rdata       (rdata),
    .misalign    (misalign),
    .err         (err),
    .stall       (stall),
    .mem         (bus)
  );

  always #5 clk = ~clk;

  // Memory: acks once mem_en has been held for ack_delay cycles.
  assign bus.mem_ack   = bus.mem_en && (wait_seen >= ack_delay);
  assign bus.mem_rdata = mem_arr[bus.mem_addr[7:0]];

  always @(posedge clk) begin
    if (poke_en) mem_arr[poke_idx] <= poke_val;
    if (bus.mem_en) en_cnt <= en_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (bus.mem_en && bus.mem_ack) begin
      wait_seen <= 0;
      if (bus.mem_we) begin
        mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end else if (bus.mem_en) begin
      wait_seen <= wait_seen + 1;
    end else begin
      wait_seen <= 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    step();
    poke_en = 1'b0;
  endtask

  // Presents a request for one cycle, then scrambles the inputs.
  task automatic issue(input string tag, input logic [1:0] wr, input logic [1:0] ls,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    mem_wr = wr; ld_size = ls; ld_unsigned = uns; addr = a; wdata = wd; req_valid = 1'b1;
    #1;
    chk({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, " idle_stall"}, {31'h0, stall}, {31'h0, (wr != 2'b00) || (ls != 2'b00)});
    step();
    req_valid = 1'b0; mem_wr = 2'b11; ld_size = 2'b11; ld_unsigned = ~uns; addr = ~a; wdata = ~wd;
  endtask

  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic txn(input string tag, input logic [1:0] wr, input logic [1:0] ls,
                     input logic uns, input logic [31:0] a, input logic [31:0] wd,
                     input int exp_lat, input logic [31:0] exp_rdata,
                     input logic exp_mis, input logic exp_err);
    issue(tag, wr, ls, uns, a, wd);
    wait_rsp(lat);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " rdata"}, rdata, exp_rdata);
    chk({tag, " misalign"}, {31'h0, misalign}, {31'h0, exp_mis});
    chk({tag, " err"}, {31'h0, err}, {31'h0, exp_err});
    chk({tag, " resp_stall"}, {31'h0, stall}, 32'h0);
    step();
    chk({tag, " rsp_pulse"}, {31'h0, rsp_valid}, 32'h0);
    chk({tag, " mem_en_after"}, {31'h0, bus.mem_en}, 32'h0);
  endtask

  initial begin
    // Reset
    step(); step();
    chk("rst ready", {31'h0, req_ready}, 32'h0);
    chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst mem_en", {31'h0, bus.mem_en}, 32'h0);
    chk("rst mem_addr", {2'b00, bus.mem_addr}, 32'h0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst stall", {31'h0, stall}, 32'h0);
    reset = 1'b1;
    poke(8'h40, 32'h8000_7F01);

    // Loads from 0x8000_7F01
    txn("lb_103",  2'b00, 2'b11, 1'b0, 32'h103, 32'h0, 2, 32'hFFFF_FF80, 1'b0, 1'b0);
    txn("lhu_102", 2'b00, 2'b10, 1'b1, 32'h102, 32'h0, 2, 32'h0000_8000, 1'b0, 1'b0);
    txn("lh_102",  2'b00, 2'b10, 1'b0, 32'h102, 32'h0, 2, 32'hFFFF_8000, 1'b0, 1'b0);
    txn("lbu_101", 2'b00, 2'b11, 1'b1, 32'h101, 32'h0, 2, 32'h0000_007F, 1'b0, 1'b0);
    txn("lw_100",  2'b00, 2'b01, 1'b0, 32'h100, 32'h0, 2, 32'h8000_7F01, 1'b0, 1'b0);

    // Misaligned: no memory traffic
    s_en = en_cnt;
    txn("lh_101_mis", 2'b00, 2'b10, 1'b0, 32'h101, 32'h0, 1, 32'h0, 1'b1, 1'b0);
    txn("sw_102_mis", 2'b01, 2'b00, 1'b0, 32'h102, 32'h1234_5678, 1, 32'h0, 1'b1, 1'b0);
    chk("mis no_mem_en", en_cnt - s_en, 0);

    // Timeout: acceptance, 5 RD cycles (counter 0..4), abort, RESP
    txn("lw_pre", 2'b00, 2'b01, 1'b0, 32'h100, 32'h0, 2, 32'h8000_7F01, 1'b0, 1'b0);
    ack_delay = 1000;
    s_en = en_cnt;
    txn("lw_tmo", 2'b00, 2'b01, 1'b0, 32'h100, 32'h0, 6, 32'h0, 1'b0, 1'b1);
    chk("tmo en_cycles", en_cnt - s_en, 6 - 1);

    // Ack arriving in the same cycle the counter sits at TIMEOUT wins
    ack_delay = 4;
    txn("lw_ack_prio", 2'b00, 2'b01, 1'b0, 32'h100, 32'h0, 6, 32'h8000_7F01, 1'b0, 1'b0);
    ack_delay = 0;

    // Stores
    poke(8'h40, 32'h1122_3344);
    s_rd = rd_cnt; s_wr = wr_cnt;
    txn("sb_101", 2'b11, 2'b00, 1'b0, 32'h101, 32'h5566_77AB, 3, 32'h0, 1'b0, 1'b0);
    chk("sb reads", rd_cnt - s_rd, 1);
    chk("sb writes", wr_cnt - s_wr, 1);
    chk("sb word", mem_arr[8'h40], 32'h1122_AB44);
    txn("sh_102", 2'b10, 2'b00, 1'b0, 32'h102, 32'hFFFF_BEEF, 3, 32'h0, 1'b0, 1'b0);
    chk("sh word", mem_arr[8'h40], 32'hBEEF_AB44);
    s_rd = rd_cnt;
    txn("sw_over_ld", 2'b01, 2'b11, 1'b0, 32'h100, 32'hCAFE_F00D, 2, 32'h0, 1'b0, 1'b0);
    chk("sw reads", rd_cnt - s_rd, 0);
    chk("sw word", mem_arr[8'h40], 32'hCAFE_F00D);

    // Null request: accepted, stays IDLE, no response
    s_rsp = rsp_cnt;
    issue("null", 2'b00, 2'b00, 1'b0, 32'h100, 32'h0);
    chk("null ready", {31'h0, req_ready}, 32'h1);
    chk("null mem_en", {31'h0, bus.mem_en}, 32'h0);
    step(); step();
    chk("null no_rsp", rsp_cnt - s_rsp, 0);

    // Reset during the RMW read of a half store
    ack_delay = 1000;
    s_wr = wr_cnt; s_rsp = rsp_cnt;
    issue("sh_rst", 2'b10, 2'b00, 1'b0, 32'h100, 32'h0000_1234);
    chk("sh_rst rmw_en", {31'h0, bus.mem_en}, 32'h1);
    chk("sh_rst rmw_we", {31'h0, bus.mem_we}, 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("sh_rst mem_en", {31'h0, bus.mem_en}, 32'h0);
    chk("sh_rst ready_low", {31'h0, req_ready}, 32'h0);
    reset = 1'b1;
    ack_delay = 0;
    #1;
    chk("sh_rst ready", {31'h0, req_ready}, 32'h1);
    step(); step(); step();
    chk("sh_rst no_write", wr_cnt - s_wr, 0);
    chk("sh_rst no_rsp", rsp_cnt - s_rsp, 0);
    chk("sh_rst word", mem_arr[8'h40], 32'hCAFE_F00D);

    // Back-to-back SW then LW to 0x200, core holds the load while stalled
    mem_wr = 2'b01; ld_size = 2'b00; addr = 32'h200; wdata = 32'h1357_9BDF; req_valid = 1'b1;
    #1;
    chk("b2b idle_stall", {31'h0, stall}, 32'h1);
    step();
    mem_wr = 2'b00; ld_size = 2'b01; ld_unsigned = 1'b0; addr = 32'h200; wdata = 32'h0;
    #1;
    chk("b2b wr_stall", {31'h0, stall}, 32'h1);
    chk("b2b wr_we", {31'h0, bus.mem_we}, 32'h1);
    step();
    chk("b2b sw_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("b2b resp1_stall", {31'h0, stall}, 32'h0);
    chk("b2b resp1_ready", {31'h0, req_ready}, 32'h0);
    step();
    chk("b2b idle2_stall", {31'h0, stall}, 32'h1);
    chk("b2b idle2_ready", {31'h0, req_ready}, 32'h1);
    step();
    req_valid = 1'b0;
    #1;
    chk("b2b rd_stall", {31'h0, stall}, 32'h1);
    step();
    chk("b2b lw_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("b2b lw_rdata", rdata, 32'h1357_9BDF);
    chk("b2b resp2_stall", {31'h0, stall}, 32'h0);
    step();
    chk("b2b end_rsp", {31'h0, rsp_valid}, 32'h0);
    chk("b2b end_stall", {31'h0, stall}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_sequencer.md
LSU_SEQUENCER -- requirements
Module: lsu_sequencer

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 8'd255, meaning the maximum number of cycles to wait for mem_ack before aborting.
REQ-002 SHALL provide clk, input, 1, rising-edge clock.
REQ-003 SHALL provide reset, input, 1, synchronous, active-low.
REQ-004 SHALL provide req_valid, input, 1, core presents a load/store request.
REQ-005 SHALL provide req_ready, output, 1, sequencer accepts a request this cycle.
REQ-006 SHALL provide mem_wr, input, 2, store size: 00 none, 01 word, 10 half, 11 byte.
REQ-007 SHALL provide ld_size, input, 2, load size: 00 none, 01 word, 10 half, 11 byte.
REQ-008 SHALL provide ld_unsigned, input, 1, zero-extend the load result when 1.
REQ-009 SHALL provide addr, input, 32, byte address.
REQ-010 SHALL provide wdata, input, 32, store data, taken from the low bits for sub-word stores.
REQ-011 SHALL provide rsp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL provide rdata, output, 32, extended load data, valid with rsp_valid.
REQ-013 SHALL provide misalign, output, 1, flags a misaligned access, valid with rsp_valid.
REQ-014 SHALL provide err, output, 1, flags a bus timeout, valid with rsp_valid.
REQ-015 SHALL provide stall, output, 1, holds the core PC and register-file write.
REQ-016 SHALL provide mem_en, mem_we, mem_addr[29:0] and mem_wdata[31:0] as outputs forming the word-wide memory port.
REQ-017 SHALL provide mem_rdata[31:0] and mem_ack as inputs from the memory port.

Function
REQ-018 SHALL implement states IDLE, RD, RMW_RD, WR and RESP.
REQ-019 SHALL drive req_ready=1 only in IDLE with reset=1.
REQ-020 SHALL latch addr, wdata, mem_wr, ld_size and ld_unsigned on acceptance (req_valid & req_ready); later changes to these inputs SHALL be ignored.
REQ-021 SHALL treat a request with mem_wr!=0 as a store, ignoring ld_size, when both fields are nonzero.
REQ-022 SHALL leave the state at IDLE with no response when an accepted request has mem_wr=00 and ld_size=00.
REQ-023 SHALL classify a request as misaligned when it is word-sized with addr[1:0]!=0, or half-sized with addr[0]!=0.
REQ-024 SHALL, for a misaligned request, perform no memory access and go IDLE->RESP with misalign=1 and rdata=0.
REQ-025 SHALL apply the following IDLE transitions on acceptance: a load goes to RD, a word store goes to WR, and a half or byte store goes to RMW_RD.
REQ-026 SHALL, in RD and RMW_RD, drive mem_en=1, mem_we=0 and mem_addr=addr[31:2] constantly until mem_ack.
REQ-027 SHALL, on mem_ack in RD, capture the extracted and extended data and go to RESP.
REQ-028 SHALL, on mem_ack in RMW_RD, store the merged word and go to WR.
REQ-029 SHALL select load lanes as follows: byte = mem_rdata[8*a+7:8*a] with a=addr[1:0]; half = mem_rdata[16*addr[1]+15:16*addr[1]]; word unchanged.
REQ-030 SHALL sign-extend sub-word load data unless ld_unsigned=1, in which case it SHALL zero-extend.
REQ-031 SHALL form the merged store word by replacing only the addressed byte or half lane with wdata[7:0] or wdata[15:0]; all other lanes SHALL keep the value read.
REQ-032 SHALL, in WR, drive mem_en=1, mem_we=1 and mem_wdata (wdata, or the merged word) constantly until mem_ack, then go to RESP.
REQ-033 SHALL ignore mem_ack in IDLE and RESP.
REQ-034 SHALL, in RESP, drive rsp_valid=1 for exactly one cycle, then return to IDLE; a new request SHALL be acceptable no earlier than the following cycle.
REQ-035 SHALL clear an 8-bit wait counter on every state entry and increment it each cycle in RD, RMW_RD or WR without mem_ack.
REQ-036 SHALL, when the wait counter reaches TIMEOUT, deassert mem_en on the next edge and go to RESP with err=1 and rdata=0; no write SHALL be issued after an RMW_RD timeout.
REQ-037 SHALL hold mem_ack priority over timeout when both occur in the same cycle.
REQ-038 SHALL drive stall=1 in RD, RMW_RD and WR, and in IDLE whenever a valid non-null request is presented; stall SHALL be 0 in RESP.
REQ-039 SHALL give minimum latency from acceptance to rsp_valid as follows: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, misaligned 1 cycle (mem_ack in the first cycle).

Reset
REQ-040 SHALL, on a clock edge with reset=0, set the state to IDLE, clear the counter and latched request, and drive rsp_valid, misalign, err, mem_en, mem_we, stall=0 and rdata, mem_addr, mem_wdata=0.
REQ-041 SHALL, on reset asserted mid-operation, abandon the access with mem_en=0 after that edge and no rsp_valid.

Verification
REQ-042 SHALL check: memory word 0x8000_7F01 at addr 0x100; LB at 0x103 signed -> rdata=0xFFFF_FF80; LHU at 0x102 -> rdata=0x0000_8000.
REQ-043 SHALL check: SB wdata=0xAB at 0x101 over word 0x1122_3344 -> one read, then a write of 0x1122_AB44, with rsp_valid 3 cycles after acceptance.
REQ-044 SHALL check: SW at 0x102 -> no mem_en, rsp_valid next cycle with misalign=1; LH at 0x101 -> misalign=1, rdata=0.
REQ-045 SHALL check: LW with mem_ack withheld and TIMEOUT=4 -> err=1 with rsp_valid after the counter reaches 4; mem_en low afterwards.
REQ-046 SHALL check: reset=0 during the RMW_RD of an SH -> no write issued and no rsp_valid; req_ready=1 once reset=1.
REQ-047 SHALL check: back-to-back SW then LW to the same address with immediate acks -> the load returns the stored value, and stall is low only in the RESP cycles.
